// File: rtl/nios_sampler_debug_pkg.sv
// Shared types and constants for the NIOS sampler debug scan slave.
package nios_sampler_debug_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_UPDATE
    } scan_state_t;

    localparam int unsigned IR_OUT_BUSY = 0;
    localparam int unsigned IR_OUT_ERR  = 1;

    localparam int unsigned DEF_IR_W = 2;
    localparam int unsigned DEF_DR_W = 38;

endpackage

// File: rtl/nios_sampler_debug_sync.sv
// Multi-flop synchroniser for one asynchronous bit, with a rising-edge strobe
// derived from the synchronised value.
module nios_sampler_debug_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic rise
);

    logic [STAGES-1:0] chain;
    logic              q_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain <= '0;
            q_d   <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
            q_d   <= chain[STAGES-1];
        end
    end

    assign q    = chain[STAGES-1];
    assign rise = chain[STAGES-1] & ~q_d;

endmodule

// File: rtl/nios_sampler_debug_scan_slave.sv
// Virtual-JTAG scan slave: captures a per-channel word, shifts it out LSB first
// while shifting a command in, and on a well-formed update issues one action strobe.
module nios_sampler_debug_scan_slave
    import nios_sampler_debug_pkg::*;
#(
    parameter int unsigned IR_W        = DEF_IR_W,
    parameter int unsigned DR_W        = DEF_DR_W,
    parameter int unsigned NCH         = 2 ** IR_W,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tck,
    input  logic                 tdi,
    input  logic                 vs_cdr,
    input  logic                 vs_sdr,
    input  logic                 vs_udr,
    input  logic                 vs_uir,
    input  logic [IR_W-1:0]      ir_in,
    input  logic [NCH*DR_W-1:0]  cap_data,
    output logic                 tdo,
    output logic [1:0]           ir_out,
    output logic [DR_W-1:0]      jdo,
    output logic [NCH-1:0]       take_action,
    output logic [NCH-1:0]       take_no_action,
    output logic                 shift_err
);

    localparam int unsigned CNT_W = $clog2(DR_W + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DR_W);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DR_W + 1);

    logic            tck_rise, udr_rise, uir_rise;
    logic            tdi_s, cdr_s, sdr_s;
    logic [IR_W-1:0] ir_s;
    logic [5+IR_W:0] unused_sync;

    nios_sampler_debug_sync #(.STAGES(SYNC_STAGES)) u_sync_tck (
        .clk(clk), .reset(reset), .d(tck), .q(unused_sync[0]), .rise(tck_rise));
    nios_sampler_debug_sync #(.STAGES(SYNC_STAGES)) u_sync_udr (
        .clk(clk), .reset(reset), .d(vs_udr), .q(unused_sync[1]), .rise(udr_rise));
    nios_sampler_debug_sync #(.STAGES(SYNC_STAGES)) u_sync_uir (
        .clk(clk), .reset(reset), .d(vs_uir), .q(unused_sync[2]), .rise(uir_rise));
    nios_sampler_debug_sync #(.STAGES(SYNC_STAGES)) u_sync_tdi (
        .clk(clk), .reset(reset), .d(tdi), .q(tdi_s), .rise(unused_sync[3]));
    nios_sampler_debug_sync #(.STAGES(SYNC_STAGES)) u_sync_cdr (
        .clk(clk), .reset(reset), .d(vs_cdr), .q(cdr_s), .rise(unused_sync[4]));
    nios_sampler_debug_sync #(.STAGES(SYNC_STAGES)) u_sync_sdr (
        .clk(clk), .reset(reset), .d(vs_sdr), .q(sdr_s), .rise(unused_sync[5]));

    for (genvar i = 0; i < IR_W; i++) begin : g_ir_sync
        nios_sampler_debug_sync #(.STAGES(SYNC_STAGES)) u_sync_ir (
            .clk(clk), .reset(reset), .d(ir_in[i]), .q(ir_s[i]), .rise(unused_sync[6+i]));
    end

    logic [DR_W-1:0] cap_ch [NCH];
    for (genvar k = 0; k < NCH; k++) begin : g_cap
        assign cap_ch[k] = cap_data[k*DR_W +: DR_W];
    end

    scan_state_t     state_q, state_d;
    logic [DR_W-1:0] sr;
    logic [CNT_W-1:0] count;
    logic [IR_W-1:0] ir_q;
    logic            err_sticky;
    logic            busy, do_capture, do_shift, do_commit, do_reject;
    logic [NCH-1:0]  ch_sel;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (tck_rise && cdr_s) state_d = ST_SHIFT;
            ST_SHIFT:  if (udr_rise) state_d = ST_UPDATE;
            ST_UPDATE: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // An update edge in SHIFT takes precedence over any coincident tck activity.
    always_comb begin
        busy       = 1'b0;
        do_capture = 1'b0;
        do_shift   = 1'b0;
        do_commit  = 1'b0;
        do_reject  = 1'b0;
        unique case (state_q)
            ST_IDLE: do_capture = tck_rise & cdr_s;
            ST_SHIFT: begin
                busy = 1'b1;
                if (!udr_rise) begin
                    do_capture = tck_rise & cdr_s;
                    do_shift   = tck_rise & sdr_s & ~cdr_s;
                end
            end
            ST_UPDATE: begin
                busy      = 1'b1;
                do_commit = (count == CNT_FULL);
                do_reject = (count != CNT_FULL);
            end
            default: ;
        endcase
    end

    assign ch_sel = NCH'(1) << ir_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr             <= '0;
            count          <= '0;
            jdo            <= '0;
            ir_q           <= '0;
            err_sticky     <= 1'b0;
            take_action    <= '0;
            take_no_action <= '0;
            shift_err      <= 1'b0;
        end else begin
            take_action    <= '0;
            take_no_action <= '0;
            shift_err      <= 1'b0;

            if (do_capture) begin
                sr    <= cap_ch[ir_q];
                count <= '0;
            end else if (do_shift) begin
                sr <= {tdi_s, sr[DR_W-1:1]};
                if (count != CNT_SAT) count <= count + 1'b1;
            end

            if (uir_rise) begin
                ir_q       <= ir_s;
                err_sticky <= 1'b0;
            end

            // ch_sel reflects ir_q before any coincident IR update.
            if (do_commit) begin
                jdo <= sr;
                if (sr[DR_W-1]) take_action    <= ch_sel;
                else            take_no_action <= ch_sel;
            end

            if (do_reject) begin
                shift_err  <= 1'b1;
                err_sticky <= 1'b1;
            end
        end
    end

    assign tdo                 = sr[0];
    assign ir_out[IR_OUT_BUSY] = busy;
    assign ir_out[IR_OUT_ERR]  = err_sticky;

endmodule

// File: tb/tb_nios_sampler_debug_scan_slave.sv
// Scoreboard bench for the scan slave: default build plus an IR_W=3/DR_W=16/SYNC=3 build.
module tb_nios_sampler_debug_scan_slave;

    localparam int DR_W = 38;
    localparam int IR_W = 2;
    localparam int NCH  = 4;
    localparam int S    = 2;

    localparam logic [DR_W-1:0] C0 = 38'h01_2345_6789;
    localparam logic [DR_W-1:0] C1 = 38'h3F_FEDC_BA98;
    localparam logic [DR_W-1:0] C2 = 38'h10_F0F0_0F0F;
    localparam logic [DR_W-1:0] C3 = 38'h2A_5555_AAAA;
    localparam logic [DR_W-1:0] P1 = 38'h3C_DEAD_BEEF;
    localparam logic [DR_W-1:0] P2 = 38'h15_0F0F_1234;
    localparam logic [DR_W-1:0] P3 = 38'h22_AAAA_5555;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic                tck, tdi, vs_cdr, vs_sdr, vs_udr, vs_uir;
    logic [IR_W-1:0]     ir_in;
    logic [NCH*DR_W-1:0] cap_data;
    logic                tdo, shift_err;
    logic [1:0]          ir_out;
    logic [DR_W-1:0]     jdo;
    logic [NCH-1:0]      take_action, take_no_action;

    nios_sampler_debug_scan_slave #(
        .IR_W(IR_W), .DR_W(DR_W), .NCH(NCH), .SYNC_STAGES(S)
    ) dut (
        .clk(clk), .reset(reset), .tck(tck), .tdi(tdi),
        .vs_cdr(vs_cdr), .vs_sdr(vs_sdr), .vs_udr(vs_udr), .vs_uir(vs_uir),
        .ir_in(ir_in), .cap_data(cap_data), .tdo(tdo), .ir_out(ir_out),
        .jdo(jdo), .take_action(take_action), .take_no_action(take_no_action),
        .shift_err(shift_err)
    );

    logic         b_tck, b_tdi, b_cdr, b_sdr, b_udr, b_uir;
    logic [2:0]   b_ir;
    logic [127:0] b_cap;
    logic         b_tdo, b_err;
    logic [1:0]   b_ir_out;
    logic [15:0]  b_jdo;
    logic [7:0]   b_ta, b_tna;

    nios_sampler_debug_scan_slave #(
        .IR_W(3), .DR_W(16), .NCH(8), .SYNC_STAGES(3)
    ) dut_b (
        .clk(clk), .reset(reset), .tck(b_tck), .tdi(b_tdi),
        .vs_cdr(b_cdr), .vs_sdr(b_sdr), .vs_udr(b_udr), .vs_uir(b_uir),
        .ir_in(b_ir), .cap_data(b_cap), .tdo(b_tdo), .ir_out(b_ir_out),
        .jdo(b_jdo), .take_action(b_ta), .take_no_action(b_tna),
        .shift_err(b_err)
    );

    typedef struct {
        logic [NCH-1:0]  ta;
        logic [NCH-1:0]  tna;
        logic            err;
        logic [DR_W-1:0] jdo;
        int              cyc;
    } exp_t;

    exp_t            sb[$];
    exp_t            mon_e;
    int              vectors = 0;
    int              miscompares = 0;
    logic [DR_W-1:0] model_jdo = '0;

    always @(negedge clk) begin
        if (reset === 1'b0 && (|take_action || |take_no_action || shift_err)) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_strobe cyc=%0d ta=%b tna=%b err=%b", cyc,
                         take_action, take_no_action, shift_err);
            end else begin
                mon_e = sb.pop_front();
                if ({take_action, take_no_action, shift_err} !== {mon_e.ta, mon_e.tna, mon_e.err}
                    || jdo !== mon_e.jdo || cyc != mon_e.cyc) begin
                    miscompares++;
                    $display("FAIL strobe got ta=%b tna=%b err=%b jdo=%h cyc=%0d want ta=%b tna=%b err=%b jdo=%h cyc=%0d",
                             take_action, take_no_action, shift_err, jdo, cyc,
                             mon_e.ta, mon_e.tna, mon_e.err, mon_e.jdo, mon_e.cyc);
                end
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tck_pulse();
        tck = 1'b1; wait_clk(3);
        tck = 1'b0; wait_clk(3);
    endtask

    task automatic set_ir(input logic [IR_W-1:0] ch);
        ir_in = ch; wait_clk(4);
        vs_uir = 1'b1; wait_clk(4);
        vs_uir = 1'b0; wait_clk(4);
    endtask

    task automatic capture();
        vs_cdr = 1'b1;
        tck_pulse();
        vs_cdr = 1'b0;
    endtask

    task automatic shift_in(input logic [63:0] data, input int n);
        vs_sdr = 1'b1;
        for (int i = 0; i < n; i++) begin
            tdi = data[i];
            tck_pulse();
        end
        vs_sdr = 1'b0;
        tdi = 1'b0;
    endtask

    task automatic push_exp(input logic [NCH-1:0] ta, input logic [NCH-1:0] tna,
                            input logic err, input logic [DR_W-1:0] new_jdo);
        exp_t e;
        if (!err) model_jdo = new_jdo;
        e.ta = ta; e.tna = tna; e.err = err; e.jdo = model_jdo; e.cyc = cyc + S + 2;
        sb.push_back(e);
    endtask

    task automatic update(input logic [NCH-1:0] ta, input logic [NCH-1:0] tna,
                          input logic err, input logic [DR_W-1:0] new_jdo);
        push_exp(ta, tna, err, new_jdo);
        vs_udr = 1'b1; wait_clk(3);
        vs_udr = 1'b0; wait_clk(6);
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 50 && sb.size() != 0; k++) wait_clk(1);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL %s_drain pending=%0d want 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        wait_clk(3);
        vectors++;
        if ({tdo, ir_out, jdo, take_action, take_no_action, shift_err} !== '0) begin
            miscompares++;
            $display("FAIL reset_hold tdo=%b ir_out=%b jdo=%h ta=%b tna=%b err=%b want all 0",
                     tdo, ir_out, jdo, take_action, take_no_action, shift_err);
        end
        reset = 1'b0;
        wait_clk(5);
        vectors++;
        if ({tdo, ir_out, jdo, take_action, take_no_action, shift_err} !== '0
            || {b_tdo, b_ir_out, b_jdo, b_ta, b_tna, b_err} !== '0) begin
            miscompares++;
            $display("FAIL reset_release a: ir_out=%b jdo=%h b: ir_out=%b jdo=%h want 0",
                     ir_out, jdo, b_ir_out, b_jdo);
        end
    endtask

    task automatic test_action();
        set_ir(2'd2);
        capture();
        shift_in(64'(P1), DR_W);
        vectors++;
        if (ir_out !== 2'b01) begin
            miscompares++;
            $display("FAIL action_busy ir_out=%b want 01", ir_out);
        end
        update(4'b0100, 4'b0000, 1'b0, P1);
        drain("action");
        vectors++;
        if (ir_out !== 2'b00 || jdo !== P1) begin
            miscompares++;
            $display("FAIL action_after ir_out=%b jdo=%h want 00 %h", ir_out, jdo, P1);
        end
    endtask

    task automatic test_no_action();
        set_ir(2'd1);
        capture();
        shift_in(64'(P2), DR_W);
        update(4'b0000, 4'b0010, 1'b0, P2);
        drain("no_action");
    endtask

    task automatic test_shift_error();
        set_ir(2'd0);
        capture();
        shift_in(64'(P3), DR_W - 1);
        update(4'b0000, 4'b0000, 1'b1, P3);
        drain("under_shift");
        vectors++;
        if (ir_out !== 2'b10 || jdo !== P2) begin
            miscompares++;
            $display("FAIL under_shift_after ir_out=%b jdo=%h want 10 %h", ir_out, jdo, P2);
        end
        capture();
        shift_in(64'(P3), DR_W + 2);
        update(4'b0000, 4'b0000, 1'b1, P3);
        drain("over_shift");
        vectors++;
        if (ir_out !== 2'b10 || jdo !== P2) begin
            miscompares++;
            $display("FAIL over_shift_after ir_out=%b jdo=%h want 10 %h", ir_out, jdo, P2);
        end
        set_ir(2'd0);
        vectors++;
        if (ir_out !== 2'b00) begin
            miscompares++;
            $display("FAIL err_clear ir_out=%b want 00", ir_out);
        end
    endtask

    task automatic test_tdo();
        logic [DR_W-1:0] exp_c;
        logic [DR_W-1:0] pat;
        exp_c = C3;
        pat   = P1;
        set_ir(2'd3);
        capture();
        vs_sdr = 1'b1;
        for (int i = 0; i < DR_W; i++) begin
            vectors++;
            if (tdo !== exp_c[i]) begin
                miscompares++;
                $display("FAIL tdo_bit%0d got %b want %b", i, tdo, exp_c[i]);
            end
            tdi = pat[i];
            tck_pulse();
        end
        vs_sdr = 1'b0;
        vectors++;
        if (tdo !== pat[0]) begin
            miscompares++;
            $display("FAIL tdo_after_shift got %b want %b", tdo, pat[0]);
        end
        update(4'b1000, 4'b0000, 1'b0, P1);
        drain("tdo");
    endtask

    task automatic test_recapture();
        logic [DR_W-1:0] exp_c;
        exp_c = C2;
        set_ir(2'd2);
        capture();
        shift_in(64'(P2), 10);
        capture();
        vectors++;
        if (tdo !== exp_c[0] || ir_out !== 2'b01) begin
            miscompares++;
            $display("FAIL recapture tdo=%b ir_out=%b want %b 01", tdo, ir_out, exp_c[0]);
        end
        shift_in(64'(P1), DR_W);
        update(4'b0100, 4'b0000, 1'b0, P1);
        drain("recapture");
        vs_udr = 1'b1; wait_clk(3);
        vs_udr = 1'b0; wait_clk(10);
        vectors++;
        if (ir_out !== 2'b00 || jdo !== P1) begin
            miscompares++;
            $display("FAIL idle_udr ir_out=%b jdo=%h want 00 %h", ir_out, jdo, P1);
        end
    endtask

    task automatic test_back_to_back();
        set_ir(2'd2);
        capture();
        shift_in(64'(P1), DR_W);
        ir_in = 2'd1;
        push_exp(4'b0100, 4'b0000, 1'b0, P1);
        vs_udr = 1'b1; wait_clk(1);
        vs_uir = 1'b1; wait_clk(3);
        vs_udr = 1'b0; vs_uir = 1'b0; wait_clk(6);
        drain("uir_in_update");
        capture();
        shift_in(64'(P2), DR_W);
        update(4'b0000, 4'b0010, 1'b0, P2);
        drain("new_ir");
    endtask

    task automatic test_reset_mid();
        set_ir(2'd1);
        capture();
        shift_in(64'(P1), 20);
        reset = 1'b1; wait_clk(3);
        model_jdo = '0;
        vectors++;
        if (ir_out !== 2'b00 || jdo !== '0 || tdo !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid ir_out=%b jdo=%h tdo=%b want 00 0 0", ir_out, jdo, tdo);
        end
        reset = 1'b0; wait_clk(3);
        vs_udr = 1'b1; wait_clk(3);
        vs_udr = 1'b0; wait_clk(10);
        vectors++;
        if (ir_out !== 2'b00 || jdo !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_udr ir_out=%b jdo=%h want 00 0", ir_out, jdo);
        end
    endtask

    task automatic b_tck_pulse();
        b_tck = 1'b1; wait_clk(3);
        b_tck = 1'b0; wait_clk(3);
    endtask

    task automatic test_wide();
        logic [15:0] pb;
        int          c0;
        int          seen;
        pb = 16'hC35A;
        seen = 0;
        b_ir = 3'd7; wait_clk(4);
        b_uir = 1'b1; wait_clk(4);
        b_uir = 1'b0; wait_clk(4);
        b_cdr = 1'b1; b_tck_pulse(); b_cdr = 1'b0;
        b_sdr = 1'b1;
        for (int i = 0; i < 16; i++) begin
            b_tdi = pb[i];
            b_tck_pulse();
        end
        b_sdr = 1'b0;
        c0 = cyc;
        b_udr = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (k == 3) b_udr = 1'b0;
            if (|b_ta || |b_tna) begin
                seen = 1;
                break;
            end
        end
        vectors++;
        if (seen == 0) begin
            miscompares++;
            $display("FAIL wide_timeout no strobe within 30 clk");
        end else if (b_ta !== 8'h80 || b_tna !== 8'h00 || b_jdo !== pb || cyc - c0 != 5) begin
            miscompares++;
            $display("FAIL wide_action ta=%b tna=%b jdo=%h lat=%0d want 10000000 0 %h 5",
                     b_ta, b_tna, b_jdo, cyc - c0, pb);
        end
        b_udr = 1'b0;
        wait_clk(4);
        vectors++;
        if (b_ta !== 8'h00 || b_ir_out !== 2'b00) begin
            miscompares++;
            $display("FAIL wide_after ta=%b ir_out=%b want 0 00", b_ta, b_ir_out);
        end
    endtask

    initial begin
        reset = 1'b1;
        {tck, tdi, vs_cdr, vs_sdr, vs_udr, vs_uir} = '0;
        ir_in = '0;
        cap_data = {C3, C2, C1, C0};
        {b_tck, b_tdi, b_cdr, b_sdr, b_udr, b_uir} = '0;
        b_ir = '0;
        b_cap = {16'hC35A, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777};

        test_reset();
        test_action();
        test_no_action();
        test_shift_error();
        test_tdo();
        test_recapture();
        test_back_to_back();
        test_reset_mid();
        test_wide();
        drain("final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
